// File: rtl/datapath_controller_if.sv
// Purpose: request/control bundle between an instruction source and the datapath sequencer.
// Latency: none (wires only).
// Backpressure: the requester raises s; the controller accepts it only while w=1.
//
// Signals:
//   s, in       requester -> controller: start request and 16-bit instruction word
//   w, illegal  controller -> requester: idle/done flag and unsupported-instruction pulse
//   datapath_in, vsel, writenum, write, readnum, loada, loadb,
//   shift, asel, bsel, ALUop, loadc, loads
//               controller -> datapath: per-cycle control strobes
interface datapath_controller_if;
    logic        s;
    logic [15:0] in;
    logic        w;
    logic        illegal;
    logic [15:0] datapath_in;
    logic        vsel;
    logic [2:0]  writenum;
    logic        write;
    logic [2:0]  readnum;
    logic        loada;
    logic        loadb;
    logic [1:0]  shift;
    logic        asel;
    logic        bsel;
    logic [1:0]  ALUop;
    logic        loadc;
    logic        loads;

    // Requester / observer side (instruction source plus datapath taps).
    modport master (
        output s, in,
        input  w, illegal, datapath_in, vsel, writenum, write, readnum,
               loada, loadb, shift, asel, bsel, ALUop, loadc, loads
    );

    // Controller side.
    modport slave (
        input  s, in,
        output w, illegal, datapath_in, vsel, writenum, write, readnum,
               loada, loadb, shift, asel, bsel, ALUop, loadc, loads
    );
endinterface

// File: rtl/datapath_controller.sv
// Purpose: Simple RISC Machine sequencer; latches one instruction and steps the datapath strobes.
// Latency: busy 2 cycles (MOV imm), 4 (MOV reg, MVN, CMP), 5 (ADD, AND) from the accepting edge.
// Backpressure: w=0 while busy; s is ignored until w returns to 1, and IR holds its value.
//
// Ports:
//   clk    rising-edge clock
//   reset  synchronous, active-high; returns to WAIT with IR cleared, aborting any instruction
//   bus    datapath_controller_if.slave: s/in in, w/illegal/control strobes out
//
// Instruction fields: opcode[15:13] op[12:11] Rn[10:8] Rd[7:5] sh[4:3] Rm[2:0] imm8[7:0]
module datapath_controller (
    input  logic                  clk,
    input  logic                  reset,
    datapath_controller_if.slave  bus
);

    typedef enum logic [2:0] {
        S_WAIT   = 3'd0,
        S_DECODE = 3'd1,
        S_WIMM   = 3'd2,
        S_GETA   = 3'd3,
        S_GETB   = 3'd4,
        S_EXEC   = 3'd5,
        S_WB     = 3'd6
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] ir_q, ir_d;

    // Instruction fields.
    logic [2:0] opcode;
    logic [1:0] op;
    logic [2:0] rn, rd, rm;
    logic [1:0] sh;

    assign opcode = ir_q[15:13];
    assign op     = ir_q[12:11];
    assign rn     = ir_q[10:8];
    assign rd     = ir_q[7:5];
    assign sh     = ir_q[4:3];
    assign rm     = ir_q[2:0];

    // Instruction classes.
    logic is_mov_imm, is_mov_reg, is_alu, is_mvn, is_cmp;

    assign is_mov_imm = (opcode == 3'b110) && (op == 2'b10);
    assign is_mov_reg = (opcode == 3'b110) && (op == 2'b00);
    assign is_alu     = (opcode == 3'b101);
    assign is_mvn     = is_alu && (op == 2'b11);
    assign is_cmp     = is_alu && (op == 2'b01);

    // Output next values (pure function of state_q and ir_q).
    logic       w_d, illegal_d, vsel_d, write_d, loada_d, loadb_d;
    logic       asel_d, bsel_d, loadc_d, loads_d;
    logic [2:0] writenum_d, readnum_d;
    logic [1:0] shift_d, aluop_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_WAIT;
            ir_q    <= 16'h0000;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        ir_d       = ir_q;
        w_d        = 1'b0;
        illegal_d  = 1'b0;
        vsel_d     = 1'b0;
        writenum_d = 3'b000;
        write_d    = 1'b0;
        readnum_d  = 3'b000;
        loada_d    = 1'b0;
        loadb_d    = 1'b0;
        shift_d    = 2'b00;
        asel_d     = 1'b0;
        bsel_d     = 1'b0;
        aluop_d    = 2'b00;
        loadc_d    = 1'b0;
        loads_d    = 1'b0;

        unique case (state_q)
            S_WAIT: begin
                w_d = 1'b1;
                // s only steers the transition; no output looks at it.
                if (bus.s) begin
                    ir_d    = bus.in;
                    state_d = S_DECODE;
                end
            end

            S_DECODE: begin
                if (is_mov_imm) begin
                    state_d = S_WIMM;
                end else if (is_mov_reg || is_mvn) begin
                    // Single-operand forms skip the A read.
                    state_d = S_GETB;
                end else if (is_alu) begin
                    state_d = S_GETA;
                end else begin
                    illegal_d = 1'b1;
                    state_d   = S_WAIT;
                end
            end

            S_WIMM: begin
                vsel_d     = 1'b1;
                writenum_d = rn;
                write_d    = 1'b1;
                state_d    = S_WAIT;
            end

            S_GETA: begin
                readnum_d = rn;
                loada_d   = 1'b1;
                state_d   = S_GETB;
            end

            S_GETB: begin
                readnum_d = rm;
                loadb_d   = 1'b1;
                shift_d   = sh;
                state_d   = S_EXEC;
            end

            S_EXEC: begin
                shift_d = sh;
                bsel_d  = 1'b0;
                // MOV-reg runs as 0 + shifted Rm; MVN ignores A, so zero it too.
                asel_d  = is_mov_reg || is_mvn;
                aluop_d = is_mov_reg ? 2'b00 : op;
                if (is_cmp) begin
                    loads_d = 1'b1;
                    state_d = S_WAIT;
                end else begin
                    loadc_d = 1'b1;
                    state_d = S_WB;
                end
            end

            S_WB: begin
                vsel_d     = 1'b0;
                writenum_d = rd;
                write_d    = 1'b1;
                state_d    = S_WAIT;
            end

            default: begin
                state_d = S_WAIT;
            end
        endcase
    end

    assign bus.w           = w_d;
    assign bus.illegal     = illegal_d;
    assign bus.datapath_in = {{8{ir_q[7]}}, ir_q[7:0]};
    assign bus.vsel        = vsel_d;
    assign bus.writenum    = writenum_d;
    assign bus.write       = write_d;
    assign bus.readnum     = readnum_d;
    assign bus.loada       = loada_d;
    assign bus.loadb       = loadb_d;
    assign bus.shift       = shift_d;
    assign bus.asel        = asel_d;
    assign bus.bsel        = bsel_d;
    assign bus.ALUop       = aluop_d;
    assign bus.loadc       = loadc_d;
    assign bus.loads       = loads_d;

endmodule

// File: doc/datapath_controller.md
Name: datapath_controller

Overview:
- Instruction sequencer for the Simple RISC Machine datapath.
- Latches one 16-bit instruction on a start handshake and decodes it.
- Drives the datapath control strobes cycle by cycle: register reads into A/B, ALU execute into C, write-back to the register file.
- Reports completion back to the requester.
- Sits between the instruction source (bench now, fetch unit later) and the datapath.

Parameters:
- None. Encoding is fixed: opcode[15:13], op[12:11], Rn[10:8], Rd[7:5], sh[4:3], Rm[2:0], imm8[7:0].

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high
- s  input  1  start request; sampled only in WAIT
- in  input  16  instruction word; captured into IR when s is accepted
- w  output  1  1 in WAIT (idle/done), 0 while busy
- illegal  output  1  one-cycle pulse when the decoded opcode/op is unsupported
- datapath_in  output  16  sign-extended IR[7:0]
- vsel  output  1  1 = datapath_in to regfile, 0 = C
- writenum  output  3  regfile write address
- write  output  1  regfile write enable
- readnum  output  3  regfile read address
- loada  output  1  load A
- loadb  output  1  load B
- shift  output  2  shifter control (IR[4:3] in GET_B/EXEC, else 00)
- asel  output  1  1 = force ALU A operand to 0
- bsel  output  1  0 = shifter output to ALU B
- ALUop  output  2  00 ADD, 01 SUB/CMP, 10 AND, 11 MVN
- loadc  output  1  load C
- loads  output  1  load status (Z)

Behaviour:
- Reset: state=WAIT, IR=0, w=1, illegal=0, and every strobe (write, loada, loadb, loadc, loads) = 0. vsel=0, asel=0, bsel=0, ALUop=00, shift=00, readnum=writenum=000. Reset wins over all other inputs, including mid-instruction; no partial write-back follows.
- Outputs are decoded from state and IR only. No output depends combinationally on s or in.
- Strobes not listed for a state are 0.
- WAIT: w=1. If s=1, IR<=in and go to DECODE; otherwise stay.
- DECODE: w=0.
  - 110_10 (MOV Rn,#imm8) -> WIMM
  - 110_00 (MOV Rd,Rm{,sh}) -> GETB
  - 101_00 / 101_01 / 101_10 -> GETA
  - 101_11 (MVN) -> GETB
  - anything else -> WAIT with illegal=1 for this cycle
- WIMM: vsel=1, writenum=Rn, write=1 -> WAIT.
- GETA: readnum=Rn, loada=1 -> GETB.
- GETB: readnum=Rm, loadb=1, shift=sh -> EXEC.
- EXEC: shift=sh, bsel=0, asel=1 for MOV-reg and MVN, else 0. ALUop=00 for MOV-reg, else IR[12:11].
  - CMP: loads=1, loadc=0 -> WAIT.
  - All others: loadc=1 (loads=0) -> WB.
- WB: vsel=0, writenum=Rd, write=1 -> WAIT.
- Busy cycles from the accepting edge until w returns to 1:
  - MOV imm: 2
  - MOV reg: 4
  - MVN: 4
  - CMP: 4
  - ADD/AND: 5
- s=1 while busy is ignored; IR must not change. s held high in WAIT immediately starts the next instruction: back-to-back operation with exactly one WAIT cycle between instructions.
- datapath_in = {{8{IR[7]}},IR[7:0]} at all times.

Test Plan:
- Reset then in=0xD007 (MOV R0,#7), s pulse -> w=0 for 2 cycles; WIMM has write=1, vsel=1, writenum=0, datapath_in=0x0007; then w=1.
- Then 0xD102 (MOV R1,#2), then 0xA148 (ADD R2,R1,R0,LSL#1) -> ADD sequence: GETA (readnum=1, loada), GETB (readnum=0, loadb, shift=01), EXEC (ALUop=00, loadc), WB (writenum=2, write, vsel=0). With the datapath attached, R2=16.
- 0xD3FF (MOV R3,#-1) -> datapath_in=0xFFFF during WIMM.
- 0xA900 (CMP R1,R0) -> EXEC has ALUop=01, loads=1, loadc=0; no write asserted in any cycle; w=0 for 4 cycles.
- in=0x0000 with s=1 -> DECODE cycle shows illegal=1; next cycle w=1; no strobe ever asserted.
- Start 0xA148, assert reset during GETA -> next cycle WAIT, w=1, all strobes 0. While busy, toggle s with a different in -> IR and sequence unchanged.
